// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller slice.
// Contents: phase encoding, per-road lamp encodings and a phase-to-lamp helper.
package traffic_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_GREEN  = 2'b00;
  localparam phase_t PH_YELLOW = 2'b01;
  localparam phase_t PH_ALLRED = 2'b10;

  // Per-road lamp triple {red, yellow, green}, one-hot.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Lamp shown by the road that owns the current phase.
  function automatic logic [2:0] phaseLamp(input phase_t ph);
    case (ph)
      PH_GREEN:  return LAMP_GRN;
      PH_YELLOW: return LAMP_YEL;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_tick_prescaler.sv
// Timing-tick prescaler: counts clk cycles 0..TICK_DIV-1 and flags a tick on the wrap cycle.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   clear - synchronous restart of the count (phase entry)
//   tick  - high during the last cycle of each TICK_DIV-cycle period
module traffic_tick_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] countQ, countD;

  // Combinational from the count only, so the FSM can act on the same edge.
  assign tick = (countQ == PW'(TICK_DIV - 1));

  always_comb begin
    countD = countQ + PW'(1);
    if (clear || tick) begin
      countD = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach vehicle-actuated intersection controller. Road 0 is the main road and rests
// green; other roads are served round-robin with min/max green, yellow and all-red timing.
// Ports:
//   clk             - system clock, rising edge
//   rst             - asynchronous active-low reset
//   vehicle_present - per-road detectors, sampled every clk
//   lights          - per road i, bits [3i+2:3i] = {red, yellow, green}
//   active_road     - road owning green/yellow, or road just cleared during all-red
//   phase           - 00 green, 01 yellow, 10 all-red
//   req_pending     - latched demand per road
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_ROADS   = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned MIN_GREEN   = 10,
  parameter int unsigned MAX_GREEN   = 30,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ROADS-1:0]         vehicle_present,
  output logic [3*NUM_ROADS-1:0]       lights,
  output logic [$clog2(NUM_ROADS)-1:0] active_road,
  output logic [1:0]                   phase,
  output logic [NUM_ROADS-1:0]         req_pending
);

  localparam int unsigned RW = $clog2(NUM_ROADS);

  localparam logic [CNT_W-1:0] MinGreenT = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MaxGreenT = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YellowT   = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] AllRedT   = CNT_W'(ALLRED_TIME);

  localparam logic [3*NUM_ROADS-1:0] LightsRst = {{(NUM_ROADS-1){LAMP_RED}}, LAMP_GRN};

  phase_t                 phaseQ, phaseD;
  logic [RW-1:0]          activeQ, activeD, targetQ, targetD, nextRoad, candidate;
  logic [CNT_W-1:0]       elapsedQ, elapsedD, elapsedInc;
  logic [NUM_ROADS-1:0]   reqQ, reqD;
  logic [3*NUM_ROADS-1:0] lightsQ, lightsD;
  logic                   tick, phaseEntry, greenEntry, others, ownPresent;

  traffic_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) uPrescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(phaseEntry),
    .tick (tick)
  );

  assign elapsedInc = (elapsedQ == '1) ? elapsedQ : elapsedQ + CNT_W'(1);
  assign ownPresent = vehicle_present[activeQ];

  // Round-robin search starting just after the active road, excluding it.
  always_comb begin
    others    = 1'b0;
    nextRoad  = '0;
    candidate = '0;
    for (int unsigned k = 1; k < NUM_ROADS; k++) begin
      candidate = RW'((int'(activeQ) + k) % NUM_ROADS);
      if (!others && reqQ[candidate]) begin
        others   = 1'b1;
        nextRoad = candidate;
      end
    end
  end

  always_comb begin
    phaseD     = phaseQ;
    activeD    = activeQ;
    targetD    = targetQ;
    greenEntry = 1'b0;
    case (phaseQ)
      PH_GREEN: begin
        if (tick) begin
          if (others && (elapsedInc >= MaxGreenT || (elapsedInc >= MinGreenT && !ownPresent))) begin
            phaseD  = PH_YELLOW;
            targetD = nextRoad;
          end else if (activeQ != '0 && elapsedInc >= MinGreenT && !ownPresent) begin
            // Nobody else waiting: hand green back to the main road.
            phaseD  = PH_YELLOW;
            targetD = '0;
          end
        end
      end
      PH_YELLOW: begin
        if (tick && elapsedInc >= YellowT) begin
          phaseD = PH_ALLRED;
        end
      end
      PH_ALLRED: begin
        if (tick && elapsedInc >= AllRedT) begin
          phaseD     = PH_GREEN;
          activeD    = targetQ;
          greenEntry = 1'b1;
        end
      end
      default: phaseD = PH_GREEN;
    endcase
    phaseEntry = (phaseD != phaseQ);
  end

  always_comb begin
    elapsedD = elapsedQ;
    if (phaseEntry) begin
      elapsedD = '0;
    end else if (tick) begin
      elapsedD = elapsedInc;
    end
  end

  // Demand latches while a road is not green; the green road and the road being
  // given green on this edge are cleared, with clear winning over set.
  always_comb begin
    reqD = '0;
    for (int unsigned i = 0; i < NUM_ROADS; i++) begin
      reqD[i] = reqQ[i] | vehicle_present[i];
      if ((phaseQ == PH_GREEN && activeQ == RW'(i)) || (greenEntry && targetQ == RW'(i))) begin
        reqD[i] = 1'b0;
      end
    end
  end

  // Lamps are decoded from next state so they change on the deciding edge.
  always_comb begin
    lightsD = '0;
    for (int unsigned i = 0; i < NUM_ROADS; i++) begin
      lightsD[3*i +: 3] = (activeD == RW'(i)) ? phaseLamp(phaseD) : LAMP_RED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phaseQ   <= PH_GREEN;
      activeQ  <= '0;
      targetQ  <= '0;
      elapsedQ <= '0;
      reqQ     <= '0;
      lightsQ  <= LightsRst;
    end else begin
      phaseQ   <= phaseD;
      activeQ  <= activeD;
      targetQ  <= targetD;
      elapsedQ <= elapsedD;
      reqQ     <= reqD;
      lightsQ  <= lightsD;
    end
  end

  assign lights      = lightsQ;
  assign active_road = activeQ;
  assign phase       = phaseQ;
  assign req_pending = reqQ;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-approach, vehicle-actuated intersection controller; successor to the two-road main/side light controller.
- Road 0 is the main road: rests green when there is no demand, and is recalled when demand clears.
- Serves other roads round-robin, with min/max green, yellow and all-red clearance timed in prescaled ticks.
- Sits at the top of the traffic design; drives the lamp outputs directly.

Parameters:
- NUM_ROADS, 4, number of approaches (2..8); road 0 = main.
- CNT_W, 8, width of the phase tick counter.
- TICK_DIV, 1, clk cycles per timing tick (>=1).
- MIN_GREEN, 10, minimum green in ticks (>=1).
- MAX_GREEN, 30, maximum green in ticks while others wait (>=MIN_GREEN, <2^CNT_W).
- YELLOW_TIME, 3, yellow duration in ticks (>=1).
- ALLRED_TIME, 1, all-red clearance in ticks (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- vehicle_present  input  NUM_ROADS  per-road detector; may be asynchronous to phase timing; sampled each clk.
- lights  output  3*NUM_ROADS  per road i, bits [3i+2:3i] = {red,yellow,green}, one-hot.
- active_road  output  $clog2(NUM_ROADS)  road currently owning green/yellow, or the road just cleared during all-red.
- phase  output  2  00=GREEN, 01=YELLOW, 10=ALLRED.
- req_pending  output  NUM_ROADS  latched demand per road.

Behaviour:
- Reset (async assert, sync-safe release):
  - phase=GREEN, active_road=0, req_pending=0, prescaler=0, elapsed=0.
  - lights: road0=001, all other roads=100.
- Reset mid-operation: immediate return to the reset state, regardless of phase.
- All outputs are registered. Road lamps other than active_road are always 100.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1; a tick fires when it wraps.
  - Prescaler and elapsed clear on every phase entry, so each phase lasts an exact multiple of TICK_DIV cycles.
  - elapsed increments per tick and saturates at 2^CNT_W-1.
- Request latch:
  - req_pending[i] sets on any cycle with vehicle_present[i]=1 while road i is not GREEN.
  - It is held 0 while road i is GREEN; clear wins over set.
- Next-road select: first i with req_pending[i]=1, searching active_road+1 upward with wrap and excluding active_road. "others" = any such i exists.
- GREEN (lamp 001), decisions evaluated only on tick with the post-increment elapsed:
  - elapsed>=MAX_GREEN and others -> YELLOW.
  - elapsed>=MIN_GREEN, vehicle_present[active]=0, others -> YELLOW.
  - active!=0, elapsed>=MIN_GREEN, vehicle_present[active]=0, no others -> YELLOW (recall to main).
  - Otherwise stay GREEN: rest indefinitely with no demand; green extends while own vehicle is present, up to MAX.
- YELLOW (lamp 010): after YELLOW_TIME ticks -> ALLRED. The target road is frozen at YELLOW entry (selected road, or 0 on recall).
- ALLRED (all lamps 100): after ALLRED_TIME ticks -> GREEN on the target; active_road updates on the same edge.
- Transition lamp changes appear on the clk edge of the deciding tick.
- Demand arriving during YELLOW/ALLRED does not change the frozen target.
- Demand on the target road itself is simply cleared at green entry.

Decomposition:
- Shared package traffic_pkg:
  - phase encoding constants PH_GREEN/PH_YELLOW/PH_ALLRED.
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- One sub-module: traffic_tick_prescaler (counter with sync clear, tick out).
- Round-robin selection and the FSM stay in traffic_phase_ctrl.

Test Plan (NUM_ROADS=4, TICK_DIV=2, MIN=4, MAX=8, YELLOW=2, ALLRED=1):
1. Assert rst=0 then release, no vehicles, run 100 cycles -> lights=12'b100_100_100_001, phase=00 throughout.
2. Pulse vehicle_present[2] for 1 cycle at cycle 3 after release -> road0 lamps:
   - 001 until cycle 8.
   - 010 for 4 cycles.
   - then all 100 for 2 cycles.
   - road2=001 at cycle 14; req_pending[2]=0 from then on.
3. Continuing test 2, road2 detector low -> after 8 cycles of green: road2 yellow 4 cycles, all-red 2 cycles, road0=001 (recall), active_road=0.
4. vehicle_present=4'b1111 held constant -> each green lasts exactly 16 cycles (MAX); service order 0->1->2->3->0.
5. Assert rst low during YELLOW of road1 -> same cycle lights=12'b100_100_100_001, phase=00, req_pending=0.
6. Road0 green with detector[0]=1, demand on road3 at elapsed=5 -> road0 stays green until the 8th tick (extension), then yellow; road3 green follows.
